// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single RAM controller.
//
// Ports:
//   clk, reset            single clock; synchronous active-high reset
//   p0_* / p1_*           requester ports (p0 = core data, p1 = loader/debug):
//                         req, we, addr, wdata in; ack pulse, rdata out
//   ram_address           latched address of the current/last transaction
//   ram_data_in           latched write data of the current/last transaction
//   ram_enable_write      one-cycle write strobe (ISSUE cycle of a write)
//   ram_data_out          RAM read data, valid the cycle after the address
//   busy                  high whenever the FSM is not in IDLE
//   grant                 port index owning the current/most recent transaction
//   dbg_state_o           FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//
// Handshake: a requester raises req and holds we/addr/wdata stable until the
// IDLE cycle in which it is sampled. From then on the transaction is owned by
// the arbiter: dropping req does not cancel it, and ack pulses for exactly one
// cycle (DONE) with rdata valid in that cycle. Requests seen outside IDLE are
// not remembered; a req still high after DONE starts a fresh transaction.

module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_enable_write,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  grant,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    grant_q;
  logic                    last_grant_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   p0_rdata_q;
  logic [DATA_WIDTH-1:0]   p1_rdata_q;

  // Port chosen if the FSM leaves IDLE this cycle. On a tie the port that
  // did not win last time goes next.
  logic grant_d;

  always_comb begin
    grant_d = 1'b0;
    if (p0_req && p1_req) begin
      grant_d = ~last_grant_q;
    end else if (p1_req) begin
      grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            state_q      <= ISSUE;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= grant_d ? p1_we    : p0_we;
            addr_q       <= grant_d ? p1_addr  : p0_addr;
            wdata_q      <= grant_d ? p1_wdata : p0_wdata;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          state_q <= DONE;
          // RAM read data is valid now; loads for writes too.
          if (grant_q) begin
            p1_rdata_q <= ram_data_out;
          end else begin
            p0_rdata_q <= ram_data_out;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobe and acks are masked by reset so a transaction caught by reset in
  // ISSUE or DONE neither writes the RAM nor completes toward the requester.
  assign ram_enable_write = (state_q == ISSUE) && we_q && !reset;
  assign p0_ack           = (state_q == DONE) && !grant_q && !reset;
  assign p1_ack           = (state_q == DONE) &&  grant_q && !reset;

  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: cycle-by-cycle vector table driven against a
// small behavioural RAM, followed by a hand-written back-to-back sequence.

module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] ram_address, ram_data_in, ram_data_out;
  logic        ram_enable_write;
  logic        busy, grant;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .p0_req           (p0_req),
    .p0_we            (p0_we),
    .p0_addr          (p0_addr),
    .p0_wdata         (p0_wdata),
    .p0_ack           (p0_ack),
    .p0_rdata         (p0_rdata),
    .p1_req           (p1_req),
    .p1_we            (p1_we),
    .p1_addr          (p1_addr),
    .p1_wdata         (p1_wdata),
    .p1_ack           (p1_ack),
    .p1_rdata         (p1_rdata),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_enable_write (ram_enable_write),
    .ram_data_out     (ram_data_out),
    .busy             (busy),
    .grant            (grant),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model: 1-cycle read, write-first ----------------
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_data_out = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_enable_write) begin
      mem[ram_address[7:0]] <= ram_data_in;
      ram_data_out          <= ram_data_in;
    end else begin
      ram_data_out <= mem[ram_address[7:0]];
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        r0, we0;
    logic [31:0] a0, d0;
    logic        r1, we1;
    logic [31:0] a1, d1;
    logic        chk;
    logic        busy, grant, ack0, ack1, wen;
    logic [31:0] addr, din, rd0, rd1;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    reset    = v.rst;
    p0_req   = v.r0;  p0_we = v.we0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req   = v.r1;  p1_we = v.we1; p1_addr = v.a1; p1_wdata = v.d1;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk("busy",  i, {31'h0, busy},             {31'h0, v.busy});
    chk("grant", i, {31'h0, grant},            {31'h0, v.grant});
    chk("p0_ack",i, {31'h0, p0_ack},           {31'h0, v.ack0});
    chk("p1_ack",i, {31'h0, p1_ack},           {31'h0, v.ack1});
    chk("ram_we",i, {31'h0, ram_enable_write}, {31'h0, v.wen});
    chk("ram_address", i, ram_address, v.addr);
    chk("ram_data_in", i, ram_data_in, v.din);
    chk("p0_rdata",    i, p0_rdata,    v.rd0);
    chk("p1_rdata",    i, p1_rdata,    v.rd1);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A0 = 32'hA0A0A0A0;
  localparam logic [31:0] B1 = 32'hB1B1B1B1;
  localparam logic [31:0] CC = 32'hCCCCCCCC;

  initial begin
    // rst r0 we0 a0 d0 | r1 we1 a1 d1 | chk busy grant ack0 ack1 wen addr din rd0 rd1
    // reset; req during reset must not be granted
    vecs[0]  = '{1,0,0,32'h00,32'h0, 0,0,32'h00,32'h0, 0, 0,0,0,0,0, 32'h00,32'h0,32'h0,32'h0};
    vecs[1]  = '{1,1,0,32'h00,32'h0, 0,0,32'h00,32'h0, 1, 0,0,0,0,0, 32'h00,32'h0,32'h0,32'h0};
    // p0 write 0x10 <- DEADBEEF (cycle N = 2); inputs change after grant
    vecs[2]  = '{0,1,1,32'h10,DB,    0,0,32'h00,32'h0, 1, 0,0,0,0,0, 32'h00,32'h0,32'h0,32'h0};
    vecs[3]  = '{0,0,0,32'h20,32'h11111111, 0,0,32'h00,32'h0, 1, 1,0,0,0,1, 32'h10,DB,32'h0,32'h0};
    vecs[4]  = '{0,0,0,32'h20,32'h11111111, 0,0,32'h00,32'h0, 1, 1,0,0,0,0, 32'h10,DB,32'h0,32'h0};
    vecs[5]  = '{0,0,0,32'h20,32'h11111111, 0,0,32'h00,32'h0, 1, 1,0,1,0,0, 32'h10,DB,DB,32'h0};
    // p1 read 0x10
    vecs[6]  = '{0,0,0,32'h00,32'h0, 1,0,32'h10,32'h0, 1, 0,0,0,0,0, 32'h10,DB,DB,32'h0};
    vecs[7]  = '{0,0,0,32'h00,32'h0, 0,0,32'h30,32'h22222222, 1, 1,1,0,0,0, 32'h10,32'h0,DB,32'h0};
    vecs[8]  = '{0,0,0,32'h00,32'h0, 0,0,32'h30,32'h22222222, 1, 1,1,0,0,0, 32'h10,32'h0,DB,32'h0};
    vecs[9]  = '{0,0,0,32'h00,32'h0, 0,0,32'h30,32'h22222222, 1, 1,1,0,1,0, 32'h10,32'h0,DB,DB};
    // reset with both reqs high, then both held: round robin p0,p1,p0
    vecs[10] = '{1,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 0,1,0,0,0, 32'h10,32'h0,DB,DB};
    vecs[11] = '{0,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 0,0,0,0,0, 32'h00,32'h0,32'h0,32'h0};
    vecs[12] = '{0,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 1,0,0,0,1, 32'h20,A0,32'h0,32'h0};
    vecs[13] = '{0,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 1,0,0,0,0, 32'h20,A0,32'h0,32'h0};
    vecs[14] = '{0,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 1,0,1,0,0, 32'h20,A0,A0,32'h0};
    vecs[15] = '{0,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 0,0,0,0,0, 32'h20,A0,A0,32'h0};
    vecs[16] = '{0,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 1,1,0,0,1, 32'h24,B1,A0,32'h0};
    vecs[17] = '{0,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 1,1,0,0,0, 32'h24,B1,A0,32'h0};
    vecs[18] = '{0,1,1,32'h20,A0, 1,1,32'h24,B1, 1, 1,1,0,1,0, 32'h24,B1,A0,B1};
    vecs[19] = '{0,1,1,32'h20,CC, 1,1,32'h24,B1, 1, 0,1,0,0,0, 32'h24,B1,A0,B1};
    // reset during ISSUE of p0 write (would write CC to 0x20): no strobe
    vecs[20] = '{1,1,1,32'h20,CC, 1,1,32'h24,B1, 1, 1,0,0,0,0, 32'h20,CC,A0,B1};
    vecs[21] = '{0,0,0,32'h00,32'h0, 0,0,32'h00,32'h0, 1, 0,0,0,0,0, 32'h00,32'h0,32'h0,32'h0};
    // p0 read 0x24 drops req in N+1; p1 raised in N+1, granted from N+4
    vecs[22] = '{0,1,0,32'h24,32'h0, 0,0,32'h00,32'h0, 1, 0,0,0,0,0, 32'h00,32'h0,32'h0,32'h0};
    vecs[23] = '{0,0,0,32'h00,32'h0, 1,0,32'h20,32'h0, 1, 1,0,0,0,0, 32'h24,32'h0,32'h0,32'h0};
    vecs[24] = '{0,0,0,32'h00,32'h0, 1,0,32'h20,32'h0, 1, 1,0,0,0,0, 32'h24,32'h0,32'h0,32'h0};
    vecs[25] = '{0,0,0,32'h00,32'h0, 1,0,32'h20,32'h0, 1, 1,0,1,0,0, 32'h24,32'h0,B1,32'h0};
    vecs[26] = '{0,0,0,32'h00,32'h0, 1,0,32'h20,32'h0, 1, 0,0,0,0,0, 32'h24,32'h0,B1,32'h0};
    vecs[27] = '{0,0,0,32'h00,32'h0, 0,0,32'h99,32'h0, 1, 1,1,0,0,0, 32'h20,32'h0,B1,32'h0};
    vecs[28] = '{0,0,0,32'h00,32'h0, 0,0,32'h99,32'h0, 1, 1,1,0,0,0, 32'h20,32'h0,B1,32'h0};
    // 0x20 still holds A0: the aborted write never reached the RAM
    vecs[29] = '{0,0,0,32'h00,32'h0, 0,0,32'h99,32'h0, 1, 1,1,0,1,0, 32'h20,32'h0,B1,A0};
    vecs[30] = '{0,0,0,32'h00,32'h0, 0,0,32'h99,32'h0, 1, 0,1,0,0,0, 32'h20,32'h0,B1,A0};
  end

  // ---------------- stimulus and checking ----------------
  initial begin
    int first_ack;
    int gap;
    bit p1_seen;

    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

    // Table: inputs applied just after a rising edge, outputs sampled on
    // the falling edge of the same cycle.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive_vec(vecs[i]);
      @(negedge clk);
      if (vecs[i].chk) check_vec(i, vecs[i]);
    end

    // Back-to-back: p0 read of 0x10 held high -> acks exactly 4 cycles apart,
    // p1 never acknowledged.
    @(posedge clk);
    #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = 32'h0;
    p1_req = 1'b0;
    first_ack = -1;
    gap = -1;
    p1_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (p1_ack) p1_seen = 1'b1;
      if (p0_ack) begin
        if (first_ack < 0) begin
          first_ack = c;
          chk("b2b_rdata", 100, p0_rdata, DB);
        end else if (gap < 0) begin
          gap = c - first_ack;
        end
      end
    end
    p0_req = 1'b0;
    chk("b2b_first_ack_seen", 101, {31'h0, first_ack >= 0}, 32'h1);
    chk("b2b_ack_gap",        102, gap, 32'd4);
    chk("b2b_no_p1_ack",      103, {31'h0, p1_seen}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the width of every address port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the width of every data port.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 p0_req  in  1  port 0 (core data port) access request.
REQ-006 p0_we  in  1  port 0 write enable (1 = write, 0 = read).
REQ-007 p0_addr  in  ADDR_WIDTH  port 0 word address.
REQ-008 p0_wdata  in  DATA_WIDTH  port 0 write data.
REQ-009 p0_ack  out  1  port 0 one-cycle completion pulse.
REQ-010 p0_rdata  out  DATA_WIDTH  port 0 read data, valid while p0_ack=1.
REQ-011 p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata SHALL mirror REQ-005..010 for port 1 (loader/debug port).
REQ-012 ram_address  out  ADDR_WIDTH  address to RAM controller.
REQ-013 ram_data_in  out  DATA_WIDTH  write data to RAM controller.
REQ-014 ram_enable_write  out  1  write strobe to RAM controller.
REQ-015 ram_data_out  in  DATA_WIDTH  read data from RAM controller; valid in the cycle after the address is sampled.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 grant  out  1  index of the port owning the current or most recent transaction.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; transitions IDLE->ISSUE (any req sampled high), ISSUE->WAIT, WAIT->DONE, DONE->IDLE, all unconditional except the first.
REQ-019 In IDLE with exactly one req high, that port SHALL be granted.
REQ-020 In IDLE with both reqs high, the port not equal to last_grant SHALL be granted (round robin); last_grant SHALL update to the granted port on the IDLE->ISSUE edge.
REQ-021 On the IDLE->ISSUE edge the granted port's we, addr and wdata SHALL be latched; later changes on that port SHALL NOT affect the transaction.
REQ-022 ram_address and ram_data_in SHALL be driven from the latched values in all states and hold them until the next grant.
REQ-023 ram_enable_write SHALL be 1 only in ISSUE and only when the latched we=1; 0 in every other cycle.
REQ-024 At the end of WAIT, ram_data_out SHALL be registered into the granted port's rdata register; for writes the register SHALL still load (value unspecified to the requester).
REQ-025 pX_ack SHALL be 1 for exactly the DONE cycle of a transaction granted to port X; never both acks in one cycle.
REQ-026 Latency: req sampled in cycle N -> RAM write strobe/address in N+1 -> ack with rdata in N+3.
REQ-027 A req deasserted after being granted SHALL NOT abort the transaction; ack SHALL still pulse.
REQ-028 Req held high through DONE SHALL be treated as a new request, sampled in the following IDLE cycle (back-to-back: one transaction per 4 cycles per port).
REQ-029 Requests arriving in ISSUE, WAIT or DONE SHALL be ignored until IDLE; no request is queued internally.
REQ-030 pX_rdata SHALL hold its value between transactions of port X.

Reset
REQ-031 On reset: state=IDLE, last_grant=1 (port 0 wins first tie), grant=0, busy=0, both acks=0, ram_enable_write=0, ram_address=0, ram_data_in=0, both rdata=0.
REQ-032 Reset asserted in any state SHALL abandon the transaction without ack; a write in ISSUE during the reset cycle SHALL NOT strobe ram_enable_write.
REQ-033 Req high during the reset cycle SHALL NOT be granted; it is first sampled in the cycle after reset deasserts.

Verification
REQ-034 Reset, then p0 write addr=0x10 data=0xDEADBEEF -> ram_enable_write=1 in cycle N+1 only with ram_address=0x10, p0_ack in N+3.
REQ-035 p1 read addr=0x10 after REQ-034 -> p1_ack in N+3 with p1_rdata=0xDEADBEEF, p0_ack stays 0.
REQ-036 Both reqs high continuously from reset -> grants alternate 0,1,0,1, acks 4 cycles apart.
REQ-037 p0 drops req in cycle N+1 after grant -> p0_ack still pulses in N+3; p1 req raised in N+1 granted in N+4.
REQ-038 Reset asserted in ISSUE of a write -> no write strobe, no ack, all outputs at reset values next cycle.
